mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single data-memory port (pmem DPI bridge) between instruction fetch (IFU, read-only)
//  and the load/store unit (LSU, read/write, byte mask). One outstanding transaction at a time;
//  round-robin grant; buffers request, waits for memory response, routes it back to the owner.
//  Sits between the IFU/LSU and the memory bridge in the single-issue core.
// PARAMETERS
//  AW       64  address width
//  DW       64  data width
//  TIMEOUT  255 cycles in WAIT before the transaction is aborted with an error response
// PORTS
//  clock        in   1      core clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  ifu_valid    in   1      IFU read request valid
//  ifu_ready    out  1      IFU request accepted this cycle
//  ifu_addr     in   AW     IFU fetch address
//  ifu_rvalid   out  1      1-cycle pulse: IFU response valid
//  ifu_rdata    out  DW     IFU read data
//  lsu_valid    in   1      LSU request valid
//  lsu_ready    out  1      LSU request accepted this cycle
//  lsu_addr     in   AW     LSU address
//  lsu_wen      in   1      1 = store, 0 = load
//  lsu_wdata    in   DW     store data
//  lsu_wmask    in   8      byte mask (0x01 b, 0x03 h, 0x0F w, 0xFF d)
//  lsu_rvalid   out  1      1-cycle pulse: LSU response (load data or store ack)
//  lsu_rdata    out  DW     LSU load data (0 for stores)
//  mem_valid    out  1      memory request valid
//  mem_ready    in   1      memory accepts request
//  mem_addr     out  AW     registered request address
//  mem_wen      out  1      registered write enable
//  mem_wdata    out  DW     registered write data
//  mem_wmask    out  8      registered mask (IFU requests: 0xFF)
//  mem_rvalid   in   1      memory response valid
//  mem_rdata    in   DW     memory read data
//  err          out  1      1-cycle pulse with rvalid when the transaction timed out
// BEHAVIOUR
//  Reset: state IDLE, owner=IFU, rr_last=LSU (so IFU wins first tie), all outputs 0, counter 0.
//  States: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  IDLE: ready driven combinationally to the selected requester only; handshake = valid&ready.
//   Arbitration: only one valid -> it wins; both valid -> the requester not in rr_last wins.
//   On handshake: latch addr/wen/wdata/mask + owner into request regs, rr_last<=owner, go REQ.
//  REQ: mem_valid=1 with latched fields held stable until mem_ready; on mem_valid&mem_ready -> WAIT.
//  WAIT: count cycles; on mem_rvalid latch mem_rdata -> RESP. Count reaching TIMEOUT -> RESP with
//   rdata=0, err flag set. mem_rvalid in the same cycle as timeout: data wins, no err.
//  RESP: one cycle; owner's rvalid=1, rdata from buffer (lsu_rdata forced 0 if wen), err if flagged;
//   -> IDLE. No new grant in RESP; min request-to-response latency = 3 cycles + memory latency.
//  Requester inputs sampled only at handshake; later changes are ignored for that transaction.
//  mem_ready in REQ same cycle as mem_rvalid (zero-latency memory): go to WAIT, rvalid captured
//   only in WAIT; memory must assert rvalid >=1 cycle after acceptance.
//  reset_n low mid-transaction: immediate return to reset state; in-flight response discarded.
//  Stray mem_rvalid outside WAIT: ignored.
// STRUCTURE
//  Shared package (core pkg): state enum {IDLE,REQ,WAIT,RESP}, owner enum {OWN_IFU,OWN_LSU},
//   mask constants MASK_B/H/W/D.
//  One sub-module: mem_rr_arb2 (2-way round-robin pick, combinational, rr_last input).
//  Remainder: FSM, request/response buffers, timeout counter ($clog2(TIMEOUT+1) bits).
// TESTING
//  IFU only, addr 0x8000_0000, mem returns 0x13 after 2 cycles -> ifu_rvalid 1 pulse, rdata 0x13, lsu_rvalid 0.
//  Both valid from reset -> IFU granted first, LSU next; held both valid -> grants alternate I,L,I,L.
//  LSU store addr 0x8000_0100 wdata 0xDEAD_BEEF mask 0x0F -> mem_wen=1, mem_wmask 0x0F, lsu_rvalid, rdata 0.
//  mem_ready low 5 cycles in REQ -> mem_addr/wdata stable all 5 cycles, no ready to requesters.
//  No mem_rvalid for TIMEOUT cycles -> owner rvalid with err=1, rdata 0; next request served normally.
//  reset_n asserted in WAIT, then memory rvalid -> no rvalid to either requester, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory-port arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-way round-robin pick between IFU and LSU
module mem_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic ifu_req_i,
    input  logic lsu_req_i,
    input  logic rr_last_i,
    output logic gnt_valid_o,
    output logic gnt_lsu_o
);

    assign gnt_valid_o = ifu_req_i | lsu_req_i;
    // On a tie the LSU wins only if the IFU held the previous grant.
    assign gnt_lsu_o   = lsu_req_i & (~ifu_req_i | (rr_last_i == logic'(OWN_IFU)));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between IFU and LSU, one transaction in flight
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ifu_valid,
    output logic          ifu_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rvalid,
    output logic [DW-1:0] ifu_rdata,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_rvalid,
    output logic [DW-1:0] lsu_rdata,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        rr_last_q, rr_last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_valid;
    logic          gnt_lsu;

    mem_rr_arb2 u_arb (
        .ifu_req_i   (ifu_valid),
        .lsu_req_i   (lsu_valid),
        .rr_last_i   (rr_last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_lsu_o   (gnt_lsu)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IFU;
            rr_last_q <= OWN_LSU;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ifu_ready = 1'b0;
        lsu_ready = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt_valid) begin
                    ifu_ready = ~gnt_lsu;
                    lsu_ready = gnt_lsu;
                    owner_d   = gnt_lsu ? OWN_LSU : OWN_IFU;
                    rr_last_d = owner_d;
                    addr_d    = gnt_lsu ? lsu_addr : ifu_addr;
                    wen_d     = gnt_lsu & lsu_wen;
                    wdata_d   = gnt_lsu ? lsu_wdata : '0;
                    wmask_d   = gnt_lsu ? lsu_wmask : MASK_D;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (mem_ready) state_d = WAIT;
            end
            WAIT: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_valid  = (state_q == REQ);
    assign mem_addr   = addr_q;
    assign mem_wen    = wen_q;
    assign mem_wdata  = wdata_q;
    assign mem_wmask  = wmask_q;
    assign ifu_rvalid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_rvalid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata  = ifu_rvalid ? rdata_q : '0;
    assign lsu_rdata  = (lsu_rvalid && !wen_q) ? rdata_q : '0;
    assign err        = (state_q == RESP) && err_q;

endmodule
